duty_ramp: RTL and testbench
============================

# duty_ramp

Duty-cycle ramp controller sitting directly upstream of the 8-bit PWM stage. Drives the PWM `Duty` input and watches the PWM counter `Q`, so duty changes are applied only at PWM period boundaries and are therefore glitch-free. It has two modes:
- **Follow:** slews `Duty` one LSB at a time toward a switch-set `Target`.
- **Breathe:** sweeps `Duty` continuously 0→255→0 as a triangle wave.

## Interface
Parameters:
- `DUTY_W`, 8: width of `Duty`, `Target` and `Q`.
- `RATE_W`, 4: width of the `Rate` prescale input.

Ports:
- `Clock`  in  1  system clock; same clock as the PWM stage; all state changes on its rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Target`  in  DUTY_W  requested duty (switch setting); used in follow mode only.
- `Mode`  in  1  0 = follow, 1 = breathe.
- `Rate`  in  RATE_W  number of PWM periods per duty step, minus 1.
- `Q`  in  DUTY_W  PWM counter value; its wrap point marks the end of a period.
- `Duty`  out  DUTY_W  registered duty value fed to the PWM stage.
- `Dir`  out  1  registered breathe direction: 1 = rising, 0 = falling.
- `AtTarget`  out  1  combinational; `(Mode == 0) && (Duty == Target)`.

## Operation
- **Period tick:** `tick = (Q == 2^DUTY_W − 1)`. This is a one-cycle condition, once per 256 clocks.
- **Prescaler `pcnt[RATE_W-1:0]`:**
  - On a tick with `pcnt >= Rate`: `pcnt <= 0` and a step event fires.
  - On a tick with `pcnt < Rate`: `pcnt <= pcnt + 1`.
  - With no tick, `pcnt` holds.
  - The `>=` comparison means lowering `Rate` mid-count never stalls the prescaler; the next tick fires a step.
- **Follow mode (`Mode` = 0), on a step event:**
  - `Duty < Target`: `Duty <= Duty + 1`.
  - `Duty > Target`: `Duty <= Duty − 1`.
  - Equal: hold.
  - `Duty` never overshoots, and a `Target` change mid-ramp simply redirects the ramp.
- **Breathe mode (`Mode` = 1), on a step event:**
  - `Dir` = 1 and `Duty` = 255: `Dir <= 0`, `Duty <= 254`.
  - `Dir` = 1 otherwise: `Duty <= Duty + 1`.
  - `Dir` = 0 and `Duty` = 0: `Dir <= 1`, `Duty <= 1`.
  - `Dir` = 0 otherwise: `Duty <= Duty − 1`.
  - Each extreme is therefore held for exactly one step. `Duty` never wraps.
- **`Dir` in follow mode:** holds its value.
- **Mode switching:**
  - Switching to breathe resumes the sweep from the current `Duty`/`Dir`.
  - Switching to follow ramps from the current `Duty` toward `Target`.
  - Neither switch resets `pcnt`.
- **Arithmetic:** unsigned DUTY_W-bit compares. Increment and decrement are guarded by the rules above, so they never wrap.
- **Reset** (asynchronous assert, any time, including mid-ramp):
  - `Duty` = 0, `Dir` = 1, `pcnt` = 0.
  - `AtTarget` = (`Mode` = 0 && `Target` = 0).
- **Reset release:** the first step event occurs at the (`Rate` + 1)th tick after release.

## Timing
- `Duty` updates on the same clock edge that samples `Q` = 255 with a step event. The PWM therefore sees the new duty from `Q` = 0 of the next period, and no period ever mixes two duty values.
- Step period = (`Rate` + 1) × 256 clocks.
- Full follow ramp 0→255 takes 255 × (`Rate` + 1) periods.
- Breathe full cycle takes 510 × (`Rate` + 1) periods.
- `AtTarget` follows `Duty`, `Mode` and `Target` combinationally, with zero-cycle latency.
- `Target`, `Mode` and `Rate` are synchronous to `Clock`; synchronising switches is the top level's job.

## Structure
- Shared package/include holds:
  - `DUTY_W` = 8 and `DUTY_MAX` = 255.
  - `MODE_FOLLOW` = 1'b0 and `MODE_BREATHE` = 1'b1.
- One sub-module, `period_prescaler`:
  - Inputs: `Clock`, `Reset_n`, `tick`, `Rate`.
  - Output: `step` pulse.
  - Holds `pcnt` and the `>=` compare.
- Top level holds the `Duty`/`Dir` registers and the mode logic.

## Test plan
- **Reset mid-ramp:** `Mode` = 0, `Target` = 200, `Rate` = 0; assert `Reset_n` low at an arbitrary cycle → `Duty` = 0 and `Dir` = 1 immediately, without waiting for a clock edge. After release, `Duty` = 1 one clock after the first `Q` = 255.
- **Follow up:** `Mode` = 0, `Target` = 5, `Rate` = 0, free-running `Q` → `Duty` steps 0,1,…,5, one step per 256 clocks, each change on the `Q` = 255 edge. Then `AtTarget` = 1 and `Duty` holds at 5.
- **Follow down and retarget:** at `Duty` = 5, set `Target` = 2 → `Duty` steps 4, 3, 2. Set `Target` = 3 at `Duty` = 4 mid-ramp → `Duty` goes 3 and stops there; no overshoot.
- **Breathe turnaround:** preload `Duty` = 254 via follow, then `Mode` = 1 → `Duty` goes 255, 254 with `Dir` 1→0. From `Duty` = 1 falling → 0, 1 with `Dir` 0→1. `Duty` never reads 256 or wraps to 255 from 0.
- **Prescale:** `Rate` = 3 → exactly one step per 1024 clocks. Lower `Rate` from 3 to 1 while `pcnt` = 2 → step fires at the next tick.
- **Mode switch:** in breathe at `Duty` = 100 falling, switch to follow with `Target` = 100 → `AtTarget` = 1 immediately and `Duty` holds at 100; `Dir` stays 0.

Source files
------------

// File: rtl/duty_ramp_pkg.sv
// duty_ramp shared constants.
// Duty width/limit and mode encodings.
package duty_ramp_pkg;

  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 8'd255;

  localparam logic MODE_FOLLOW  = 1'b0;
  localparam logic MODE_BREATHE = 1'b1;

endpackage

// File: rtl/period_prescaler.sv
// Counts PWM period ticks; pulses step every Rate+1 ticks.
// In: Clock, Reset_n, tick, Rate. Out: step.
module period_prescaler #(
  parameter int RATE_W = 4
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              tick,
  input  logic [RATE_W-1:0] Rate,
  output logic              step
);

  logic [RATE_W-1:0] r_pcnt;
  logic              w_done;

  // >= so lowering Rate mid-count fires on the next tick
  assign w_done = (r_pcnt >= Rate);
  assign step   = tick && w_done;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pcnt <= '0;
    end else if (tick) begin
      if (w_done) r_pcnt <= '0;
      else        r_pcnt <= r_pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/duty_ramp.sv
// Glitch-free duty ramp (follow / breathe) for an 8-bit PWM.
// In: Clock, Reset_n, Target, Mode, Rate, Q. Out: Duty, Dir, AtTarget.
module duty_ramp #(
  parameter int DUTY_W = 8,
  parameter int RATE_W = 4
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic [DUTY_W-1:0] Target,
  input  logic              Mode,
  input  logic [RATE_W-1:0] Rate,
  input  logic [DUTY_W-1:0] Q,
  output logic [DUTY_W-1:0] Duty,
  output logic              Dir,
  output logic              AtTarget
);

  import duty_ramp_pkg::*;

  localparam logic [DUTY_W-1:0] TOP = '1;
  localparam logic [DUTY_W-1:0] ONE = DUTY_W'(1);

  logic [DUTY_W-1:0] r_duty;
  logic              r_dir;
  logic [DUTY_W-1:0] w_duty_nxt;
  logic              w_dir_nxt;
  logic              w_tick;
  logic              w_step;

  // counter wrap: last clock of the PWM period
  assign w_tick = (Q == TOP);

  period_prescaler #(
    .RATE_W (RATE_W)
  ) u_pre (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .tick    (w_tick),
    .Rate    (Rate),
    .step    (w_step)
  );

  always_comb begin
    w_duty_nxt = r_duty;
    w_dir_nxt  = r_dir;
    if (w_step) begin
      if (Mode == MODE_FOLLOW) begin
        if (r_duty < Target)
          w_duty_nxt = r_duty + ONE;
        else if (r_duty > Target)
          w_duty_nxt = r_duty - ONE;
      end else if (r_dir) begin
        if (r_duty == TOP) begin
          w_dir_nxt  = 1'b0;
          w_duty_nxt = TOP - ONE;
        end else begin
          w_duty_nxt = r_duty + ONE;
        end
      end else begin
        if (r_duty == '0) begin
          w_dir_nxt  = 1'b1;
          w_duty_nxt = ONE;
        end else begin
          w_duty_nxt = r_duty - ONE;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_duty <= '0;
      r_dir  <= 1'b1;
    end else begin
      r_duty <= w_duty_nxt;
      r_dir  <= w_dir_nxt;
    end
  end

  assign Duty     = r_duty;
  assign Dir      = r_dir;
  assign AtTarget = (Mode == MODE_FOLLOW) &&
                    (r_duty == Target);

endmodule

// File: tb/tb_duty_ramp.sv
// Directed bench for duty_ramp.
// Vector table plus reset/prescale/timing sequences.
module tb_duty_ramp;

  logic       clk;
  logic       rst_n;
  logic [7:0] tgt;
  logic       mode;
  logic [3:0] rate;
  logic [7:0] q;
  logic [7:0] duty;
  logic       dir;
  logic       at;

  int n_cmp;
  int n_bad;

  duty_ramp #(
    .DUTY_W (8),
    .RATE_W (4)
  ) dut (
    .Clock    (clk),
    .Reset_n  (rst_n),
    .Target   (tgt),
    .Mode     (mode),
    .Rate     (rate),
    .Q        (q),
    .Duty     (duty),
    .Dir      (dir),
    .AtTarget (at)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       m;
    logic [7:0] t;
    int         n;
    logic [7:0] e_duty;
    logic       e_dir;
    logic       e_at;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string nm,
                     input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // one fast period boundary: Q=255 for one clock
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      q = 8'd255;
      clk1();
      q = 8'd0;
      clk1();
    end
  endtask

  // free-running counter for n clocks from 0
  task automatic run_q(input int n);
    for (int i = 0; i < n; i++) begin
      q = 8'(i);
      clk1();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vt[0]  = '{1'b0, 8'd5,   1,   8'd1,   1'b1, 1'b0};
    vt[1]  = '{1'b0, 8'd5,   4,   8'd5,   1'b1, 1'b1};
    vt[2]  = '{1'b0, 8'd5,   3,   8'd5,   1'b1, 1'b1};
    vt[3]  = '{1'b0, 8'd2,   1,   8'd4,   1'b1, 1'b0};
    vt[4]  = '{1'b0, 8'd3,   1,   8'd3,   1'b1, 1'b1};
    vt[5]  = '{1'b0, 8'd3,   2,   8'd3,   1'b1, 1'b1};
    vt[6]  = '{1'b0, 8'd254, 251, 8'd254, 1'b1, 1'b1};
    vt[7]  = '{1'b1, 8'd254, 1,   8'd255, 1'b1, 1'b0};
    vt[8]  = '{1'b1, 8'd254, 1,   8'd254, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 8'd254, 253, 8'd1,   1'b0, 1'b0};
    vt[10] = '{1'b1, 8'd254, 1,   8'd0,   1'b0, 1'b0};
    vt[11] = '{1'b1, 8'd254, 1,   8'd1,   1'b1, 1'b0};
    vt[12] = '{1'b1, 8'd254, 1,   8'd2,   1'b1, 1'b0};
    vt[13] = '{1'b1, 8'd254, 254, 8'd254, 1'b0, 1'b0};
    vt[14] = '{1'b1, 8'd254, 154, 8'd100, 1'b0, 1'b0};
    vt[15] = '{1'b0, 8'd100, 0,   8'd100, 1'b0, 1'b1};
    vt[16] = '{1'b0, 8'd100, 2,   8'd100, 1'b0, 1'b1};

    rst_n = 1'b0;
    mode  = 1'b0;
    tgt   = 8'd0;
    rate  = 4'd0;
    q     = 8'd0;
    repeat (3) clk1();
    chk("rst_duty", int'(duty), 0);
    chk("rst_dir",  int'(dir),  1);
    chk("rst_at",   int'(at),   1);
    rst_n = 1'b1;
    clk1();

    for (int k = 0; k < 17; k++) begin
      mode = vt[k].m;
      tgt  = vt[k].t;
      #1;
      ticks(vt[k].n);
      chk($sformatf("v%0d_duty", k),
          int'(duty), int'(vt[k].e_duty));
      chk($sformatf("v%0d_dir", k),
          int'(dir), int'(vt[k].e_dir));
      chk($sformatf("v%0d_at", k),
          int'(at), int'(vt[k].e_at));
    end

    // prescale: Rate=3 -> step every 4th tick
    tgt  = 8'd200;
    rate = 4'd3;
    for (int i = 0; i < 3; i++) begin
      ticks(1);
      chk($sformatf("pre_hold%0d", i),
          int'(duty), 100);
    end
    ticks(1);
    chk("pre_step4", int'(duty), 101);
    ticks(2);
    chk("pre_pc2", int'(duty), 101);
    rate = 4'd1;
    ticks(1);
    chk("pre_lower", int'(duty), 102);

    // Rate=3 free-running: one step per 1024 clocks
    rate = 4'd3;
    run_q(768);
    chk("pre_768", int'(duty), 102);
    run_q(256);
    chk("pre_1024", int'(duty), 103);

    // asynchronous reset mid-period
    rate = 4'd0;
    q    = 8'd10;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_duty", int'(duty), 0);
    chk("arst_dir",  int'(dir),  1);
    chk("arst_at",   int'(at),   0);
    clk1();
    rst_n = 1'b1;
    run_q(255);
    chk("rel_q254", int'(duty), 0);
    q = 8'd255;
    clk1();
    chk("rel_q255", int'(duty), 1);
    q = 8'd0;
    clk1();
    chk("rel_hold", int'(duty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
